// File: rtl/fetch_ctrl_if.sv
// Fetch-controller bus: instruction-memory handshake plus decode-side hand-off.
interface fetch_ctrl_if;
    localparam int unsigned XLEN = 32;

    // instruction memory handshake
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            inst_ce;

    // decode-side hand-off
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            inst_valid;
    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] fetch_cnt;

    // fetch controller side
    modport master (
        output imem_req, imem_addr, inst_ce,
        output pc, inst, inst_valid, fetch_cnt,
        input  imem_ack, imem_rdata,
        input  stall, redirect, redirect_pc
    );

    // memory / decode side
    modport slave (
        input  imem_req, imem_addr, inst_ce,
        input  pc, inst, inst_valid, fetch_cnt,
        output imem_ack, imem_rdata,
        output stall, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/ack handshake,
// presents one instruction at a time to decode, and handles stalls/redirects
// including a redirect that lands while a fetch is still outstanding.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'h0000_0004
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);

    localparam int unsigned XLEN    = 32;
    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] BOOT  = 2'd0;
    localparam logic [STATE_W-1:0] FETCH = 2'd1;
    localparam logic [STATE_W-1:0] VALID = 2'd2;

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic [STATE_W-1:0] state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    addr_q, addr_d;
    logic               req_q, req_d;
    logic               ce_q, ce_d;
    logic [XLEN-1:0]    inst_q, inst_d;
    logic               valid_q, valid_d;
    logic [XLEN-1:0]    cnt_q, cnt_d;
    logic               pend_flush_q, pend_flush_d;
    logic [XLEN-1:0]    pend_pc_q, pend_pc_d;

    logic [XLEN-1:0]    redirect_tgt_c;
    logic [XLEN-1:0]    flush_tgt_c;
    logic [XLEN-1:0]    pc_inc_c;
    logic               ack_c;

    // Word-aligned redirect target, sequential successor, and qualified ack
    always_comb begin
        redirect_tgt_c = bus.redirect_pc & ALIGN_MASK;
        pc_inc_c       = pc_q + PC_INC;
        ack_c          = req_q & bus.imem_ack;
        flush_tgt_c    = bus.redirect ? redirect_tgt_c : pend_pc_q;
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        req_d        = req_q;
        ce_d         = ce_q;
        inst_d       = inst_q;
        valid_d      = valid_q;
        cnt_d        = cnt_q;
        pend_flush_d = pend_flush_q;
        pend_pc_d    = pend_pc_q;

        case (state_q)
            BOOT: begin
                ce_d    = 1'b1;
                req_d   = 1'b1;
                addr_d  = pc_q;
                state_d = FETCH;
            end

            FETCH: begin
                if (ack_c) begin
                    if (pend_flush_q || bus.redirect) begin
                        // Returned word belongs to the abandoned path: drop it
                        pc_d         = flush_tgt_c;
                        addr_d       = flush_tgt_c;
                        pend_flush_d = 1'b0;
                        req_d        = 1'b1;
                    end else begin
                        inst_d  = bus.imem_rdata;
                        valid_d = 1'b1;
                        req_d   = 1'b0;
                        state_d = VALID;
                    end
                end else if (bus.redirect) begin
                    // Address must stay stable until ack; remember the target
                    pend_flush_d = 1'b1;
                    pend_pc_d    = redirect_tgt_c;
                end
            end

            VALID: begin
                if (bus.redirect) begin
                    // Squash the held instruction; it is not counted
                    valid_d = 1'b0;
                    pc_d    = redirect_tgt_c;
                    addr_d  = redirect_tgt_c;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end else if (!bus.stall) begin
                    cnt_d   = cnt_q + XLEN'(1);
                    pc_d    = pc_inc_c;
                    addr_d  = pc_inc_c;
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end
            end

            default: begin
                req_d   = 1'b0;
                ce_d    = 1'b0;
                valid_d = 1'b0;
                state_d = BOOT;
            end
        endcase
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            req_q        <= 1'b0;
            ce_q         <= 1'b0;
            inst_q       <= '0;
            valid_q      <= 1'b0;
            cnt_q        <= '0;
            pend_flush_q <= 1'b0;
            pend_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            req_q        <= req_d;
            ce_q         <= ce_d;
            inst_q       <= inst_d;
            valid_q      <= valid_d;
            cnt_q        <= cnt_d;
            pend_flush_q <= pend_flush_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = addr_q;
    assign bus.inst_ce    = ce_q;
    assign bus.pc         = pc_q;
    assign bus.inst       = inst_q;
    assign bus.inst_valid = valid_q;
    assign bus.fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl.
module tb_fetch_ctrl;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    fetch_ctrl_if bus ();

    fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .PC_INC   (32'h0000_0004)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle past the edge before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++; if (bus.pc !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h expected %h", bus.pc, 32'h0); end
        tests_run++; if (bus.imem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr: got %h expected %h", bus.imem_addr, 32'h0); end
        tests_run++; if (bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
        tests_run++; if (bus.inst_ce !== 1'b0) begin tests_failed++; $display("FAIL reset_ce: got %b expected 0", bus.inst_ce); end
        tests_run++; if (bus.inst !== 32'h0) begin tests_failed++; $display("FAIL reset_inst: got %h expected %h", bus.inst, 32'h0); end
        tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", bus.inst_valid); end
        tests_run++; if (bus.fetch_cnt !== 32'h0) begin tests_failed++; $display("FAIL reset_cnt: got %0d expected 0", bus.fetch_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_boot();
        tick();
        tests_run++; if (bus.imem_req !== 1'b1) begin tests_failed++; $display("FAIL boot_req: got %b expected 1", bus.imem_req); end
        tests_run++; if (bus.inst_ce !== 1'b1) begin tests_failed++; $display("FAIL boot_ce: got %b expected 1", bus.inst_ce); end
        tests_run++; if (bus.imem_addr !== 32'h0) begin tests_failed++; $display("FAIL boot_addr: got %h expected %h", bus.imem_addr, 32'h0); end
    endtask

    task automatic test_sequential();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2001_0005;
        tick();
        bus.imem_ack = 1'b0;
        tests_run++; if (bus.inst_valid !== 1'b1) begin tests_failed++; $display("FAIL seq0_valid: got %b expected 1", bus.inst_valid); end
        tests_run++; if (bus.inst !== 32'h2001_0005) begin tests_failed++; $display("FAIL seq0_inst: got %h expected %h", bus.inst, 32'h2001_0005); end
        tests_run++; if (bus.pc !== 32'h0) begin tests_failed++; $display("FAIL seq0_pc: got %h expected %h", bus.pc, 32'h0); end
        tests_run++; if (bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL seq0_req: got %b expected 0", bus.imem_req); end
        tick();
        tests_run++; if (bus.imem_req !== 1'b1) begin tests_failed++; $display("FAIL seq1_req: got %b expected 1", bus.imem_req); end
        tests_run++; if (bus.imem_addr !== 32'h4) begin tests_failed++; $display("FAIL seq1_addr: got %h expected %h", bus.imem_addr, 32'h4); end
        tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL seq1_valid: got %b expected 0", bus.inst_valid); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2002_0007;
        tick();
        bus.imem_ack = 1'b0;
        tests_run++; if (bus.inst !== 32'h2002_0007) begin tests_failed++; $display("FAIL seq1_inst: got %h expected %h", bus.inst, 32'h2002_0007); end
        tests_run++; if (bus.pc !== 32'h4) begin tests_failed++; $display("FAIL seq1_pc: got %h expected %h", bus.pc, 32'h4); end
        tick();
        tests_run++; if (bus.fetch_cnt !== 32'd2) begin tests_failed++; $display("FAIL seq_cnt: got %0d expected 2", bus.fetch_cnt); end
        tests_run++; if (bus.imem_addr !== 32'h8) begin tests_failed++; $display("FAIL seq2_addr: got %h expected %h", bus.imem_addr, 32'h8); end
    endtask

    task automatic test_wait_states();
        // stall held high in FETCH must have no effect
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin tests_failed++; $display("FAIL wait_hold%0d: got req=%b addr=%h expected req=1 addr=%h", i, bus.imem_req, bus.imem_addr, 32'h8); end
            tests_run++; if (bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL wait_valid%0d: got %b expected 0", i, bus.inst_valid); end
        end
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h3003_0009;
        tick();
        bus.imem_ack = 1'b0; bus.stall = 1'b0;
        tests_run++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h3003_0009) begin tests_failed++; $display("FAIL wait_data: got valid=%b inst=%h expected valid=1 inst=%h", bus.inst_valid, bus.inst, 32'h3003_0009); end
        tick();
        tests_run++; if (bus.fetch_cnt !== 32'd3 || bus.imem_addr !== 32'hC) begin tests_failed++; $display("FAIL wait_next: got cnt=%0d addr=%h expected cnt=3 addr=%h", bus.fetch_cnt, bus.imem_addr, 32'hC); end
    endtask

    task automatic test_stall();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h4004_000B;
        tick();
        bus.imem_ack = 1'b0; bus.stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h4004_000B || bus.pc !== 32'hC) begin tests_failed++; $display("FAIL stall_hold%0d: got valid=%b inst=%h pc=%h expected valid=1 inst=%h pc=%h", i, bus.inst_valid, bus.inst, bus.pc, 32'h4004_000B, 32'hC); end
            tests_run++; if (bus.imem_req !== 1'b0 || bus.fetch_cnt !== 32'd3) begin tests_failed++; $display("FAIL stall_idle%0d: got req=%b cnt=%0d expected req=0 cnt=3", i, bus.imem_req, bus.fetch_cnt); end
        end
        bus.stall = 1'b0;
        tick();
        tests_run++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10 || bus.fetch_cnt !== 32'd4) begin tests_failed++; $display("FAIL stall_release: got req=%b addr=%h cnt=%0d expected req=1 addr=%h cnt=4", bus.imem_req, bus.imem_addr, bus.fetch_cnt, 32'h10); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        for (int k = 0; k < 4; k++) begin
            exp_pc = 32'h10 + 32'(4 * k);
            bus.imem_ack = 1'b1; bus.imem_rdata = 32'h5000_0000 | 32'(k);
            tick();
            bus.imem_ack = 1'b0;
            tests_run++; if (bus.inst !== (32'h5000_0000 | 32'(k)) || bus.pc !== exp_pc) begin tests_failed++; $display("FAIL b2b_inst%0d: got inst=%h pc=%h expected inst=%h pc=%h", k, bus.inst, bus.pc, 32'h5000_0000 | 32'(k), exp_pc); end
            tick();
            tests_run++; if (bus.imem_addr !== exp_pc + 32'h4 || bus.fetch_cnt !== 32'(5 + k)) begin tests_failed++; $display("FAIL b2b_next%0d: got addr=%h cnt=%0d expected addr=%h cnt=%0d", k, bus.imem_addr, bus.fetch_cnt, exp_pc + 32'h4, 5 + k); end
        end
    endtask

    task automatic test_redirect_pending();
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0303;
        tick();
        bus.redirect = 1'b0;
        tests_run++; if (bus.imem_addr !== 32'h20 || bus.imem_req !== 1'b1) begin tests_failed++; $display("FAIL pend_hold0: got addr=%h req=%b expected addr=%h req=1", bus.imem_addr, bus.imem_req, 32'h20); end
        // second redirect while still waiting overrides the first
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0103;
        tick();
        bus.redirect = 1'b0;
        tests_run++; if (bus.imem_addr !== 32'h20 || bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL pend_hold1: got addr=%h valid=%b expected addr=%h valid=0", bus.imem_addr, bus.inst_valid, 32'h20); end
        tick();
        tests_run++; if (bus.imem_addr !== 32'h20) begin tests_failed++; $display("FAIL pend_hold2: got %h expected %h", bus.imem_addr, 32'h20); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.imem_ack = 1'b0;
        tests_run++; if (bus.imem_addr !== 32'h100 || bus.pc !== 32'h100 || bus.imem_req !== 1'b1) begin tests_failed++; $display("FAIL pend_target: got addr=%h pc=%h req=%b expected addr=%h pc=%h req=1", bus.imem_addr, bus.pc, bus.imem_req, 32'h100, 32'h100); end
        tests_run++; if (bus.inst_valid !== 1'b0 || bus.inst === 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL pend_discard: got valid=%b inst=%h expected valid=0 and stale word dropped", bus.inst_valid, bus.inst); end
        tick();
        tests_run++; if (bus.imem_addr !== 32'h100 || bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL pend_cleared: got addr=%h valid=%b expected addr=%h valid=0", bus.imem_addr, bus.inst_valid, 32'h100); end
        // redirect coinciding with ack: data dropped, target taken at once
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAAD_F00D;
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0040;
        tick();
        bus.imem_ack = 1'b0; bus.redirect = 1'b0;
        tests_run++; if (bus.imem_addr !== 32'h40 || bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1) begin tests_failed++; $display("FAIL ackredir: got addr=%h valid=%b req=%b expected addr=%h valid=0 req=1", bus.imem_addr, bus.inst_valid, bus.imem_req, 32'h40); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h6006_0001;
        tick();
        bus.imem_ack = 1'b0;
        tests_run++; if (bus.inst_valid !== 1'b1 || bus.pc !== 32'h40 || bus.fetch_cnt !== 32'd8) begin tests_failed++; $display("FAIL ackredir_data: got valid=%b pc=%h cnt=%0d expected valid=1 pc=%h cnt=8", bus.inst_valid, bus.pc, bus.fetch_cnt, 32'h40); end
    endtask

    task automatic test_redirect_stall();
        bus.stall = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0200;
        tick();
        bus.stall = 1'b0; bus.redirect = 1'b0;
        tests_run++; if (bus.imem_addr !== 32'h200 || bus.pc !== 32'h200 || bus.imem_req !== 1'b1) begin tests_failed++; $display("FAIL rs_target: got addr=%h pc=%h req=%b expected addr=%h pc=%h req=1", bus.imem_addr, bus.pc, bus.imem_req, 32'h200, 32'h200); end
        tests_run++; if (bus.fetch_cnt !== 32'd8 || bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rs_squash: got cnt=%0d valid=%b expected cnt=8 valid=0", bus.fetch_cnt, bus.inst_valid); end
    endtask

    task automatic test_wrap();
        // low target bits are masked off
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0;
        bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFF;
        tick();
        bus.redirect = 1'b0;
        tests_run++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_align: got %h expected %h", bus.imem_addr, 32'hFFFF_FFFC); end
        bus.imem_rdata = 32'h7007_0003;
        tick();
        bus.imem_ack = 1'b0;
        tests_run++; if (bus.inst_valid !== 1'b1 || bus.pc !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_valid: got valid=%b pc=%h expected valid=1 pc=%h", bus.inst_valid, bus.pc, 32'hFFFF_FFFC); end
        tick();
        tests_run++; if (bus.imem_addr !== 32'h0 || bus.pc !== 32'h0 || bus.fetch_cnt !== 32'd9) begin tests_failed++; $display("FAIL wrap_next: got addr=%h pc=%h cnt=%0d expected addr=%h pc=%h cnt=9", bus.imem_addr, bus.pc, bus.fetch_cnt, 32'h0, 32'h0); end
    endtask

    task automatic test_reset_mid_wait();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1111_2222;
        tick();
        bus.imem_ack = 1'b0;
        tick();
        tests_run++; if (bus.imem_addr !== 32'h4 || bus.imem_req !== 1'b1 || bus.fetch_cnt !== 32'd10) begin tests_failed++; $display("FAIL rmw_pre: got addr=%h req=%b cnt=%0d expected addr=%h req=1 cnt=10", bus.imem_addr, bus.imem_req, bus.fetch_cnt, 32'h4); end
        tick();
        rst = 1'b1;
        tick();
        tests_run++; if (bus.pc !== 32'h0 || bus.imem_addr !== 32'h0 || bus.fetch_cnt !== 32'h0) begin tests_failed++; $display("FAIL rmw_regs: got pc=%h addr=%h cnt=%0d expected pc=%h addr=%h cnt=0", bus.pc, bus.imem_addr, bus.fetch_cnt, 32'h0, 32'h0); end
        tests_run++; if (bus.imem_req !== 1'b0 || bus.inst_ce !== 1'b0 || bus.inst !== 32'h0 || bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rmw_outs: got req=%b ce=%b inst=%h valid=%b expected all zero", bus.imem_req, bus.inst_ce, bus.inst, bus.inst_valid); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0;
        tick();
        tests_run++; if (bus.inst_valid !== 1'b0 || bus.inst !== 32'h0) begin tests_failed++; $display("FAIL rmw_ack_in_rst: got valid=%b inst=%h expected valid=0 inst=%h", bus.inst_valid, bus.inst, 32'h0); end
        rst = 1'b0;
        tick();
        tests_run++; if (bus.imem_req !== 1'b1 || bus.inst_ce !== 1'b1 || bus.imem_addr !== 32'h0 || bus.inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rmw_boot: got req=%b ce=%b addr=%h valid=%b expected req=1 ce=1 addr=%h valid=0", bus.imem_req, bus.inst_ce, bus.imem_addr, bus.inst_valid, 32'h0); end
        bus.imem_rdata = 32'h8008_0001;
        tick();
        bus.imem_ack = 1'b0;
        tests_run++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h8008_0001 || bus.fetch_cnt !== 32'h0) begin tests_failed++; $display("FAIL rmw_refetch: got valid=%b inst=%h cnt=%0d expected valid=1 inst=%h cnt=0", bus.inst_valid, bus.inst, bus.fetch_cnt, 32'h8008_0001); end
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        rst             = 1'b1;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;

        test_reset();
        test_boot();
        test_sequential();
        test_wait_states();
        test_stall();
        test_back_to_back();
        test_redirect_pending();
        test_redirect_stall();
        test_wrap();
        test_reset_mid_wait();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the single-cycle CPU front end.
- Owns the PC register and computes PC+4.
- Drives the instruction-memory request/acknowledge handshake and presents one fetched instruction at a time to decode.
- Handles decode stalls and branch/jump redirects, including a redirect that arrives while a fetch is still outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.
- PC_INC, 32'h4, PC increment per sequentially consumed instruction.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address (registered; equals pc during request).
- imem_ack  in  1  memory returns imem_rdata this cycle; only sampled while imem_req=1.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- inst_ce  out  1  instruction-memory chip enable; 0 in reset and BOOT, 1 otherwise.
- pc  out  32  address of the instruction currently being fetched or held.
- inst  out  32  fetched instruction.
- inst_valid  out  1  inst/pc are valid for decode.
- stall  in  1  decode cannot accept; hold current instruction.
- redirect  in  1  branch/jump taken; one-cycle pulse.
- redirect_pc  in  32  target address; bits [1:0] forced to 0 internally.
- fetch_cnt  out  32  count of instructions consumed (wraps mod 2^32).

Behaviour:
- Reset values: pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, inst_ce=0, inst=0, inst_valid=0, fetch_cnt=0, pend_flush=0, pend_pc=0, state=BOOT.
- Reset applies in any state. An outstanding request is abandoned, and any imem_ack arriving during or after reset, before a new request is issued, is ignored.
- BOOT: one cycle. Next edge sets inst_ce=1, imem_req=1, imem_addr=pc, and moves to FETCH.
- FETCH:
  - imem_req stays 1 and imem_addr stays stable until imem_ack=1. There is no limit on wait cycles.
  - redirect without ack: set pend_flush=1 and pend_pc=redirect_pc. The address does not change. A later redirect overwrites pend_pc (last wins).
  - ack with pend_flush=0 and redirect=0: inst<=imem_rdata, inst_valid<=1, imem_req<=0, go to VALID. Fetch latency from request issue is (wait cycles + 1).
  - ack with pend_flush=1 or redirect=1: discard the data. pc and imem_addr take the target (redirect_pc if redirect=1 this cycle, else pend_pc). Clear pend_flush, keep imem_req=1, stay in FETCH.
- VALID: inst_valid=1; inst and pc held stable.
  - redirect=1 (priority over stall): inst_valid<=0, pc<=redirect_pc, imem_addr<=redirect_pc, imem_req<=1, go to FETCH. fetch_cnt is not incremented (instruction squashed).
  - redirect=0, stall=0: instruction consumed this cycle. fetch_cnt+=1, pc<=pc+PC_INC, imem_addr<=pc+PC_INC, inst_valid<=0, imem_req<=1, go to FETCH.
  - redirect=0, stall=1: hold all state.
- Arithmetic: pc+PC_INC is 32-bit, wraps (32'hFFFF_FFFC -> 32'h0000_0000).
- stall is ignored outside VALID.
- imem_ack with imem_req=0 is ignored.
- Sustained rate without wait states: one instruction per 2 cycles (FETCH, VALID).

Test Plan:
- Reset, then zero-wait memory returning 32'h2001_0005 at 0x0 and 32'h2002_0007 at 0x4, stall=0 -> BOOT then req at 0x0; inst_valid with inst=32'h2001_0005, pc=0; next fetch at 0x4; fetch_cnt=2 after both consumed.
- Memory inserts 3 wait cycles at 0x8 -> imem_req and imem_addr=0x8 held 4 cycles; inst_valid rises the cycle after ack.
- stall=1 for 5 cycles while VALID at pc=0xC -> inst, pc and inst_valid unchanged, no request, fetch_cnt unchanged; release -> request at 0x10.
- redirect to 32'h0000_0103 while FETCH at 0x20 waiting -> address stays 0x20 until ack; data discarded; next request at 0x100; inst_valid stays 0 throughout.
- redirect and stall together in VALID at pc=0x40, target 0x200 -> request at 0x200, fetch_cnt not incremented.
- Sequential at pc=32'hFFFF_FFFC consumed -> next fetch at 0x0. Assert rst mid-wait, then ack arrives -> all outputs at reset values, ack ignored, BOOT restarts at RESET_PC.
